// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and helpers for the exhaustive truth-table sweep checker
package tt_sweep_pkg;
    localparam int MAX_N_IN = 10;

    typedef enum logic [1:0] {IDLE, HOLDV, DONE} state_e;

    function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/tt_sweep_checker_vec_gen.sv
// sweep_vec_gen: vector sequencer for the sweep checker (index, hold timing, binary/Gray mapping)
//   clk, rst       clock, synchronous active-high reset
//   load_i         restart the sequence at vector 0 and latch gray_i
//   gray_i         sweep order for the next sequence (0 binary, 1 Gray)
//   run_i          sequence is advancing this cycle
//   clear_i        force vec_o back to 0 (cancelled sweep)
//   vec_o          current stimulus vector
//   sample_en_o    this edge ends the hold of vec_o and samples the DUT
//   last_o         the sample this edge is the final vector of the sweep
module sweep_vec_gen import tt_sweep_pkg::*; #(
    parameter int N_IN = 4,
    parameter int HOLD = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            gray_i,
    input  logic            run_i,
    input  logic            clear_i,
    output logic [N_IN-1:0] vec_o,
    output logic            sample_en_o,
    output logic            last_o
);
    localparam int NVEC = 2**N_IN;
    localparam int IW   = N_IN + 1;
    localparam int HW   = HOLD > 1 ? $clog2(HOLD) : 1;

    // one extra index bit so the final increment never wraps back to 0
    logic [IW-1:0]   idx_q;
    logic [HW-1:0]   hold_q;
    logic            gray_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] nxt_b;
    logic [N_IN-1:0] nxt_v;

    assign vec_o       = vec_q;
    assign sample_en_o = run_i && (hold_q == HW'(HOLD - 1));
    assign last_o      = sample_en_o && (idx_q == IW'(NVEC - 1));
    assign nxt_b       = N_IN'(idx_q + 1'b1);
    assign nxt_v       = gray_q ? N_IN'(bin2gray(MAX_N_IN'(nxt_b))) : nxt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            hold_q <= '0;
            gray_q <= 1'b0;
            vec_q  <= '0;
        end else if (load_i) begin
            idx_q  <= '0;
            hold_q <= '0;
            gray_q <= gray_i;
            vec_q  <= '0;
        end else if (clear_i) begin
            vec_q  <= '0;
        end else if (sample_en_o) begin
            hold_q <= '0;
            idx_q  <= idx_q + 1'b1;
            // the final vector stays on the bus once the sweep completes
            if (!last_o)
                vec_q <= nxt_v;
        end else if (run_i) begin
            hold_q <= hold_q + 1'b1;
        end
    end
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustive-sweep engine comparing a combinational DUT against a truth table
//   clk, rst            clock, synchronous active-high reset
//   start_i             begin a sweep when not busy
//   abort_i             cancel a running sweep
//   gray_mode_i         0 binary order, 1 Gray order (latched at start)
//   expected_tt_i       truth table, row i at [i*N_OUT +: N_OUT] (latched at start)
//   vec_o               stimulus to the DUT inputs
//   dut_out_i           DUT response
//   busy_o, done_o      sweep running / sweep completed
//   pass_o              with done_o: no mismatching vector
//   err_count_o         mismatching vectors, saturating at 2**N_IN
//   first_err_valid_o   a mismatch was seen since start
//   first_err_idx_o     vector of the first mismatch
module tt_sweep_checker import tt_sweep_pkg::*; #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int HOLD  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic                        gray_mode_i,
    input  logic [N_OUT*(2**N_IN)-1:0]  expected_tt_i,
    output logic [N_IN-1:0]             vec_o,
    input  logic [N_OUT-1:0]            dut_out_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [N_IN:0]               err_count_o,
    output logic                        first_err_valid_o,
    output logic [N_IN-1:0]             first_err_idx_o
);
    localparam int NVEC = 2**N_IN;
    localparam int EW   = N_IN + 1;

    state_e                   state_q, state_d;
    logic [N_OUT*NVEC-1:0]    exp_q;
    logic [EW-1:0]            err_q;
    logic                     fev_q;
    logic [N_IN-1:0]          fei_q;
    logic                     accept, run, clear, sample_en, last, mismatch;
    logic [N_OUT-1:0]         row;

    assign accept   = start_i && state_q != HOLDV;
    // abort beats the sample that would otherwise land on the same edge
    assign run      = state_q == HOLDV && !abort_i;
    assign clear    = state_q == HOLDV && abort_i;
    // rows are addressed by the vector actually driven, so Gray order checks the right row
    assign row      = exp_q[int'(vec_o) * N_OUT +: N_OUT];
    assign mismatch = sample_en && dut_out_i != row;

    sweep_vec_gen #(.N_IN(N_IN), .HOLD(HOLD)) u_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .gray_i      (gray_mode_i),
        .run_i       (run),
        .clear_i     (clear),
        .vec_o       (vec_o),
        .sample_en_o (sample_en),
        .last_o      (last)
    );

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = HOLDV;
        else if (clear)
            state_d = IDLE;
        else if (last)
            state_d = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
            err_q <= '0;
            fev_q <= 1'b0;
            fei_q <= '0;
        end else if (accept) begin
            exp_q <= expected_tt_i;
            err_q <= '0;
            fev_q <= 1'b0;
            fei_q <= '0;
        end else if (mismatch) begin
            err_q <= err_q == EW'(NVEC) ? err_q : err_q + 1'b1;
            fev_q <= 1'b1;
            if (!fev_q)
                fei_q <= vec_o;
        end
    end

    assign busy_o            = state_q == HOLDV;
    assign done_o            = state_q == DONE;
    assign pass_o            = done_o && err_q == '0;
    assign err_count_o       = err_q;
    assign first_err_valid_o = fev_q;
    assign first_err_idx_o   = fei_q;
endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Parametrised, synthesizable exhaustive-sweep engine for N_IN-input combinational blocks. It drives every input vector, holds each for HOLD cycles, samples the DUT outputs and compares them against a programmed truth table. It reports a mismatch count, the first failing index and pass/done.
Used in lab self-check harnesses in front of Week-03-style logic functions. Supports binary or Gray-code sweep order.

Parameters:
N_IN, 4, number of DUT inputs; sweep covers 2**N_IN vectors (1..10)
N_OUT, 1, number of DUT outputs checked per vector (1..8)
HOLD, 20, clock cycles each vector is held; >=1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a sweep when not busy
abort  in  1  pulse; cancels a running sweep
gray_mode  in  1  0 = binary order, 1 = Gray order; latched at start
expected_tt  in  N_OUT*2**N_IN  expected outputs; slice [i*N_OUT +: N_OUT] = truth row for input value i; latched at start
vec  out  N_IN  stimulus to DUT inputs (MSB = first input, e.g. a)
dut_out  in  N_OUT  DUT response
busy  out  1  sweep in progress
done  out  1  sweep completed; held until next start or rst
pass  out  1  valid when done=1; 1 iff err_count==0
err_count  out  N_IN+1  mismatching vectors; saturates at 2**N_IN
first_err_valid  out  1  at least one mismatch since start
first_err_idx  out  N_IN  vec value of first mismatch

Behaviour:
- Reset (rst=1 at edge): state IDLE; vec=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_idx=0. Reset overrides start/abort and aborts any sweep mid-operation.
- FSM states: IDLE, HOLDV, DONE.
  - IDLE/DONE + start -> HOLDV.
  - HOLDV + abort -> IDLE.
  - HOLDV + last sample -> DONE.
- Start acceptance (edge E0, state IDLE or DONE):
  - latch gray_mode and expected_tt;
  - idx=0, hold_cnt=0, vec=map(0);
  - clear err_count, first_err_*, pass; busy=1, done=0.
- start while busy: ignored.
- map(i) = i in binary mode; i ^ (i>>1) in Gray mode.
- HOLDV: vec stays constant for exactly HOLD cycles.
  - At the edge where hold_cnt==HOLD-1, sample dut_out and compare with latched slice [vec*N_OUT +: N_OUT]. Index by vec, not idx, so Gray mode checks the correct row.
  - On mismatch: err_count+1 (saturating).
  - On the first mismatch: first_err_valid=1, first_err_idx=vec.
  - Same edge: hold_cnt=0, idx+1, vec=map(idx+1).
- Last vector (idx==2**N_IN-1) sampled at edge E0+HOLD*2**N_IN:
  - state DONE, busy=0, done=1;
  - pass = no mismatch, including the final sample;
  - vec holds the last value.
  - Total latency from the start edge to done=1 is exactly HOLD*2**N_IN cycles (320 at defaults).
- Abort in HOLDV: next edge IDLE, busy=0, done=0, vec=0; err_count and first_err_* are kept for debug. Abort in IDLE/DONE is ignored.
- start and abort together while busy: abort wins. In IDLE/DONE: start wins.
- idx counter is N_IN+1 bits wide, so it terminates without wrap-around at N_IN=10.
- HOLD=1: a new vector every cycle, with a sample at every edge.

Decomposition:
- Package tt_sweep_pkg: state enum (IDLE, HOLDV, DONE); function bin2gray(N_IN); localparam NVEC=2**N_IN.
- Sub-module sweep_vec_gen: idx counter, hold counter and binary/Gray mapping. Outputs vec, sample_en and last. The top level keeps the FSM, compare and error bookkeeping.

Test Plan:
1. Defaults; bench DUT f=ab|cd; expected_tt=16'hF888; binary mode; start -> vec steps 0..15, 20 cycles each; done=1 exactly 320 cycles after the start edge; pass=1, err_count=0.
2. Same setup with gray_mode=1 -> vec order 0,1,3,2,6,7,5,4,12,...,8; consecutive vecs differ in exactly 1 bit; pass=1 at cycle 320.
3. Defaults, binary mode, bench DUT f=ab|cd:
   - expected_tt=16'hF889 -> err_count=1, first_err_idx=0, pass=0;
   - expected_tt=16'h0000 -> err_count=7, first_err_idx=3.
4. Abort asserted 100 cycles after start -> next edge busy=0, done=0, vec=0. A new start then completes normally with pass=1 at +320.
5. start pulse at cycle 50 of a sweep -> ignored; done still at 320. rst at cycle 150 -> all outputs at reset values after that edge; no done.
6. N_IN=2, N_OUT=2, HOLD=1; expected_tt=8'b10_01_01_00 from a half-adder DUT -> done 4 cycles after start, pass=1. Flip one DUT output bit on vec=3 -> err_count=1, first_err_idx=3.
